// File: rtl/paddle_avm_writer_if.sv
// -----------------------------------------------------------------------------
// paddle_avm_writer_if
//
// Avalon-MM bus bundle between the paddle position writer (master) and the
// paddle-position PIO slave. Carries only the signals a single-word
// write/read master needs.
//
// Signals:
//   avm_address      [1:0]  slave word address          (master -> slave)
//   avm_chipselect          transaction valid           (master -> slave)
//   avm_write_n             active-low write strobe     (master -> slave)
//   avm_writedata   [31:0]  write data                  (master -> slave)
//   avm_readdata    [31:0]  read data                   (slave  -> master)
//   avm_waitrequest         slave stall                 (slave  -> master)
// -----------------------------------------------------------------------------
interface paddle_avm_writer_if;

  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_writedata,
    output avm_readdata,
    output avm_waitrequest
  );

endinterface : paddle_avm_writer_if

// File: rtl/paddle_avm_writer.sv
// -----------------------------------------------------------------------------
// paddle_avm_writer
//
// Avalon-MM master that owns one paddle's vertical position. Once per frame
// tick it samples the up/down buttons, moves the paddle by STEP pixels with
// clamping to [Y_MIN, Y_MAX], and whenever the position changes it pushes the
// new value into the paddle PIO with a single-word write. Position changes
// that arrive while a write is stalled coalesce into one follow-up write of
// the latest value.
//
// Optional feature (compile-time macro PADDLE_READBACK_VERIFY_EN):
//   after each write the master reads the PIO register back; a mismatch sets
//   the sticky verify_err flag and schedules a rewrite of the current
//   position. Without the macro avm_readdata is ignored and verify_err is 0.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   btn_up     move-up request, active-high, asynchronous to clk
//   btn_down   move-down request, active-high, asynchronous to clk
//   avm        Avalon-MM master port (paddle_avm_writer_if.master)
//   paddle_y   current internal position
//   busy       write in progress or pending
//   verify_err sticky readback mismatch flag
// -----------------------------------------------------------------------------
module paddle_avm_writer #(
  parameter int Y_WIDTH     = 10,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 400,
  parameter int Y_INIT      = 200,
  parameter int STEP        = 4,
  parameter int TICK_DIV    = 833333,
  parameter int TARGET_ADDR = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       btn_up,
  input  logic                       btn_down,
  paddle_avm_writer_if.master        avm,
  output logic [Y_WIDTH-1:0]         paddle_y,
  output logic                       busy,
  output logic                       verify_err
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  // Position arithmetic runs one bit wider than the position so that a step
  // below zero shows up as a borrow in the top bit instead of wrapping.
  localparam int YX_W = Y_WIDTH + 1;
  localparam logic [Y_WIDTH:0]   Y_MIN_X  = YX_W'(Y_MIN);
  localparam logic [Y_WIDTH:0]   Y_MAX_X  = YX_W'(Y_MAX);
  localparam logic [Y_WIDTH:0]   STEP_X   = YX_W'(STEP);
  localparam logic [Y_WIDTH-1:0] Y_INIT_V = Y_WIDTH'(Y_INIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE
`ifdef PADDLE_READBACK_VERIFY_EN
    , S_VERIFY
`endif
  } state_t;

  // ---------------------------------------------------------------------------
  // Button synchronizers: plain 2-flop level synchronizers. The level is used
  // directly, so holding a button keeps the paddle moving every tick.
  // ---------------------------------------------------------------------------
  logic [1:0] up_sync_q;
  logic [1:0] dn_sync_q;
  logic       up_s;
  logic       dn_s;

  // NOTE: clocked state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      up_sync_q <= 2'b00;
      dn_sync_q <= 2'b00;
    end else begin
      up_sync_q <= {up_sync_q[0], btn_up};
      dn_sync_q <= {dn_sync_q[0], btn_down};
    end
  end

  assign up_s = up_sync_q[1];
  assign dn_s = dn_sync_q[1];

  // ---------------------------------------------------------------------------
  // Frame tick: counter runs 0..TICK_DIV-1; tick is high on the cycle whose
  // rising edge wraps the counter back to 0.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] tick_cnt_q;
  logic             tick;

  assign tick = (tick_cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Position update
  // ---------------------------------------------------------------------------
  logic [Y_WIDTH-1:0] y_q;
  logic [Y_WIDTH:0]   y_ext;
  logic [Y_WIDTH:0]   y_dec;
  logic [Y_WIDTH:0]   y_inc;
  logic [Y_WIDTH:0]   y_cand;
  logic               moved;

  assign y_ext = {1'b0, y_q};
  assign y_dec = y_ext - STEP_X;
  assign y_inc = y_ext + STEP_X;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    y_cand = y_ext;
    unique case ({up_s, dn_s})
      2'b10: begin
        // A set top bit is a borrow: the step went below zero.
        if (y_dec[Y_WIDTH] || (y_dec < Y_MIN_X)) y_cand = Y_MIN_X;
        else                                     y_cand = y_dec;
      end
      2'b01: begin
        if (y_inc > Y_MAX_X) y_cand = Y_MAX_X;
        else                 y_cand = y_inc;
      end
      default: y_cand = y_ext;
    endcase
  end

  // A clamped step that lands on the current value is not a change.
  assign moved = tick && (y_cand != y_ext);

  // ---------------------------------------------------------------------------
  // Bus FSM: state register plus combinational next-state / bus outputs.
  // ---------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  logic   pending_q;
  logic   start_wr;
  logic   cs;
  logic   wr_n;
  logic   vfy_fail;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

`ifdef PADDLE_READBACK_VERIFY_EN
  logic vfy_done;
`endif

  always_comb begin
    state_d  = state_q;
    start_wr = 1'b0;
    cs       = 1'b0;
    wr_n     = 1'b1;
`ifdef PADDLE_READBACK_VERIFY_EN
    vfy_done = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          start_wr = 1'b1;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        cs   = 1'b1;
        wr_n = 1'b0;
        if (!avm.avm_waitrequest) begin
`ifdef PADDLE_READBACK_VERIFY_EN
          state_d = S_VERIFY;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef PADDLE_READBACK_VERIFY_EN
      S_VERIFY: begin
        cs = 1'b1;
        if (!avm.avm_waitrequest) begin
          vfy_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: position, pending flag, latched write data and the
  // sticky verify error.
  // ---------------------------------------------------------------------------
  logic [Y_WIDTH-1:0] wdata_q;

`ifdef PADDLE_READBACK_VERIFY_EN
  logic verify_err_q;

  assign vfy_fail = vfy_done && (avm.avm_readdata[Y_WIDTH-1:0] != wdata_q);

  always_ff @(posedge clk) begin
    if (reset)         verify_err_q <= 1'b0;
    else if (vfy_fail) verify_err_q <= 1'b1;
  end

  assign verify_err = verify_err_q;
`else
  assign vfy_fail   = 1'b0;
  assign verify_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q       <= Y_INIT_V;
      pending_q <= 1'b1;          // forces the initial write of Y_INIT
      wdata_q   <= '0;
    end else begin
      if (tick) y_q <= y_cand[Y_WIDTH-1:0];

      // A new change (or a failed readback) wins over the clear that goes
      // with launching a write: the launched data is the pre-tick position,
      // so the fresh value still needs its own write.
      if (moved || vfy_fail) pending_q <= 1'b1;
      else if (start_wr)     pending_q <= 1'b0;

      // Latched once at launch, held stable for the whole transfer.
      if (start_wr) wdata_q <= y_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign avm.avm_address    = 2'(TARGET_ADDR);
  assign avm.avm_chipselect = cs;
  assign avm.avm_write_n    = wr_n;
  assign avm.avm_writedata  = {{(32 - Y_WIDTH){1'b0}}, wdata_q};

  assign paddle_y = y_q;
  assign busy     = pending_q || (state_q != S_IDLE);

endmodule : paddle_avm_writer

// File: tb/tb_paddle_avm_writer.sv
// -----------------------------------------------------------------------------
// tb_paddle_avm_writer
//
// Self-checking bench for paddle_avm_writer. A behavioural model steps the
// paddle position once per TICK_DIV clock edges using plain integer min/max,
// records every change it predicts, and the bus monitor records every
// completed write; the two histories are compared per phase. Buttons only
// change right after a tick so they are fully synchronized by the next one.
// -----------------------------------------------------------------------------
module tb_paddle_avm_writer;

  localparam int Y_WIDTH  = 10;
  localparam int Y_MIN    = 0;
  localparam int Y_MAX    = 400;
  localparam int Y_INIT   = 200;
  localparam int STEP     = 4;
  localparam int TICK_DIV = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               btn_up = 1'b0;
  logic               btn_down = 1'b0;
  logic [Y_WIDTH-1:0] paddle_y;
  logic               busy;
  logic               verify_err;

  paddle_avm_writer_if bus ();

  paddle_avm_writer #(
    .Y_WIDTH     (Y_WIDTH),
    .Y_MIN       (Y_MIN),
    .Y_MAX       (Y_MAX),
    .Y_INIT      (Y_INIT),
    .STEP        (STEP),
    .TICK_DIV    (TICK_DIV),
    .TARGET_ADDR (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .avm        (bus),
    .paddle_y   (paddle_y),
    .busy       (busy),
    .verify_err (verify_err)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Slave model: waitrequest driver and a one-word register for readback.
  // ---------------------------------------------------------------------------
  logic        rand_wait  = 1'b0;
  logic        wait_force = 1'b0;
  logic        corrupt    = 1'b0;
  logic [31:0] mem        = '0;

  initial bus.avm_waitrequest = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rand_wait) bus.avm_waitrequest = ($urandom_range(0, 2) == 0);
    else           bus.avm_waitrequest = wait_force;
  end

  assign bus.avm_readdata = corrupt ? 32'd0 : mem;

  // ---------------------------------------------------------------------------
  // Bus monitor (samples on the falling edge)
  // ---------------------------------------------------------------------------
  int          obs_q[$];
  int          cs_cycles = 0;
  int          wr_cycles = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_val  = '0;

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else if (bus.avm_chipselect && !bus.avm_write_n) begin
      cs_cycles++;
      wr_cycles++;
      check("wdata_upper_zero", {22'd0, bus.avm_writedata[31:Y_WIDTH]}, 32'd0);
      check("wr_address", {30'd0, bus.avm_address}, 32'd0);
      if (stall_prev) check("wdata_stable_in_stall", bus.avm_writedata, stall_val);
      stall_prev = bus.avm_waitrequest;
      stall_val  = bus.avm_writedata;
      if (!bus.avm_waitrequest) begin
        obs_q.push_back(int'(bus.avm_writedata));
        mem = bus.avm_writedata;
      end
    end else begin
      if (bus.avm_chipselect) cs_cycles++;
      stall_prev = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: one position step per TICK_DIV edges after reset.
  // ---------------------------------------------------------------------------
  int model_y  = Y_INIT;
  int model_ny = Y_INIT;
  int edge_n   = 0;
  int tick_cnt = 0;
  int exp_q[$];

  always @(posedge clk) begin
    if (reset) begin
      edge_n  = 0;
      model_y = Y_INIT;
    end else begin
      edge_n++;
      if (edge_n % TICK_DIV == 0) begin
        model_ny = model_y;
        if (btn_up && !btn_down)
          model_ny = (model_y - STEP < Y_MIN) ? Y_MIN : model_y - STEP;
        else if (btn_down && !btn_up)
          model_ny = (model_y + STEP > Y_MAX) ? Y_MAX : model_y + STEP;
        if (model_ny != model_y) exp_q.push_back(model_ny);
        model_y = model_ny;
        tick_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick();
    int t0;
    int k;
    t0 = tick_cnt;
    k  = 0;
    while (tick_cnt == t0 && k < 2 * TICK_DIV) begin
      step(1);
      k++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 200) begin
      step(1);
      k++;
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(3);
    check("rst_cs",         {31'd0, bus.avm_chipselect}, 32'd0);
    check("rst_write_n",    {31'd0, bus.avm_write_n},    32'd1);
    check("rst_address",    {30'd0, bus.avm_address},    32'd0);
    check("rst_writedata",  bus.avm_writedata,           32'd0);
    check("rst_busy",       {31'd0, busy},               32'd1);
    check("rst_paddle_y",   {22'd0, paddle_y},           32'(Y_INIT));
    check("rst_verify_err", {31'd0, verify_err},         32'd0);
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back(Y_INIT);
    cs_cycles = 0;
    wr_cycles = 0;
  endtask

  task automatic compare_obs(input string tag, input int want[$]);
    check({tag, "_nwrites"}, obs_q.size(), want.size());
    for (int i = 0; i < want.size() && i < obs_q.size(); i++)
      check({tag, "_write"}, obs_q[i], want[i]);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int want[$];
    int cs0;
    int j;
    logic [1:0] b;

    // 1: reset then a single one-cycle write of Y_INIT.
    do_reset();
    wait_idle("t1");
    compare_obs("t1", exp_q);
    check("t1_wr_cycles", wr_cycles, 1);
    check("t1_paddle_y", {22'd0, paddle_y}, 32'(Y_INIT));

    // 2: hold down for three ticks, one write per tick.
    btn_down = 1'b1;
    for (int t = 0; t < 3; t++) begin
      wait_tick();
      check("t2_paddle_y", {22'd0, paddle_y}, 32'(Y_INIT + STEP * (t + 1)));
    end
    btn_down = 1'b0;
    wait_idle("t2");
    compare_obs("t2", exp_q);
    check("t2_wr_cycles", wr_cycles, 4);

    // 4: both buttons together leave the paddle alone and the bus quiet.
    cs0 = cs_cycles;
    btn_up   = 1'b1;
    btn_down = 1'b1;
    for (int t = 0; t < 5; t++) begin
      wait_tick();
      check("t4_paddle_y", {22'd0, paddle_y}, 32'd212);
    end
    btn_up   = 1'b0;
    btn_down = 1'b0;
    step(4);
    check("t4_cs_cycles", cs_cycles - cs0, 0);

    // 3: run up into the bottom limit and keep pushing; no wrap, no
    // extra write once clamped.
    btn_up = 1'b1;
    for (int t = 0; t < 56; t++) begin
      wait_tick();
      check("t3_paddle_y", {22'd0, paddle_y}, model_y);
    end
    btn_up = 1'b0;
    wait_idle("t3");
    check("t3_at_min", {22'd0, paddle_y}, 32'(Y_MIN));
    compare_obs("t3", exp_q);

    // Run down into the top limit.
    btn_down = 1'b1;
    for (int t = 0; t < 103; t++) begin
      wait_tick();
      check("tmax_paddle_y", {22'd0, paddle_y}, model_y);
    end
    btn_down = 1'b0;
    wait_idle("tmax");
    check("tmax_at_max", {22'd0, paddle_y}, 32'(Y_MAX));
    compare_obs("tmax", exp_q);

    // Random buttons per tick with a randomly stalling slave.
    exp_q.delete();
    obs_q.delete();
    rand_wait = 1'b1;
    for (int t = 0; t < 40; t++) begin
      b = 2'($urandom_range(0, 3));
      btn_up   = b[1];
      btn_down = b[0];
      wait_tick();
      check("rnd_paddle_y", {22'd0, paddle_y}, model_y);
    end
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    rand_wait = 1'b0;
    step(2);
    wait_idle("rnd");
    if (exp_q.size() > 0) begin
      check("rnd_has_write", {31'd0, obs_q.size() > 0}, 32'd1);
      if (obs_q.size() > 0) check("rnd_last_write", obs_q[obs_q.size() - 1], model_y);
    end
    // Every write must be one of the predicted positions, in order.
    j = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      while (j < exp_q.size() && exp_q[j] != obs_q[i]) j++;
      check("rnd_write_in_order", {31'd0, j < exp_q.size()}, 32'd1);
      j++;
    end

    // 5: initial write stalled while two down-ticks occur; coalesced
    // follow-up carries only the final value.
    wait_force = 1'b1;
    do_reset();
    btn_down = 1'b1;
    wait_tick();
    check("t5_paddle_y1", {22'd0, paddle_y}, 32'd204);
    wait_tick();
    btn_down = 1'b0;
    check("t5_paddle_y2", {22'd0, paddle_y}, 32'd208);
    check("t5_cs_stalled", {31'd0, bus.avm_chipselect}, 32'd1);
    check("t5_wdata_stalled", bus.avm_writedata, 32'd200);
    wait_force = 1'b0;
    step(2);
    wait_idle("t5");
    want.delete();
    want.push_back(200);
    want.push_back(208);
    compare_obs("t5", want);

    // Reset in the middle of a stalled write releases the bus next edge.
    wait_force = 1'b1;
    do_reset();
    step(2);
    check("rmid_cs_before", {31'd0, bus.avm_chipselect}, 32'd1);
    reset = 1'b1;
    step(1);
    check("rmid_cs_after", {31'd0, bus.avm_chipselect}, 32'd0);
    check("rmid_write_n",  {31'd0, bus.avm_write_n},    32'd1);
    check("rmid_busy",     {31'd0, busy},               32'd1);
    reset = 1'b0;
    wait_force = 1'b0;
    obs_q.delete();
    step(2);
    wait_idle("rmid");
    want.delete();
    want.push_back(Y_INIT);
    compare_obs("rmid", want);

`ifdef PADDLE_READBACK_VERIFY_EN
    // 6: readback returns 0 for the write of 204 -> sticky error + rewrite.
    do_reset();
    wait_idle("t6_init");
    obs_q.delete();
    corrupt  = 1'b1;
    btn_down = 1'b1;
    wait_tick();
    btn_down = 1'b0;
    check("t6_paddle_y", {22'd0, paddle_y}, 32'd204);
    j = 0;
    while (!verify_err && j < 50) begin
      step(1);
      j++;
    end
    corrupt = 1'b0;
    check("t6_verify_err_set", {31'd0, verify_err}, 32'd1);
    wait_idle("t6");
    step(5);
    check("t6_verify_err_sticky", {31'd0, verify_err}, 32'd1);
    want.delete();
    want.push_back(204);
    want.push_back(204);
    compare_obs("t6", want);
    do_reset();
    wait_idle("t6_after");
`else
    check("no_verify_err", {31'd0, verify_err}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_paddle_avm_writer

// File: doc/paddle_avm_writer.md
Name: paddle_avm_writer

Overview:
Avalon-MM master (initiator) that owns one paddle's vertical position and pushes it into the paddle-position PIO output slave (10-bit, register at address 0).
- Samples up/down buttons once per frame tick.
- Updates the position with clamping.
- Issues a single-word write to the PIO whenever the position changes.
- Sits between board buttons and the Qsys fabric port of the paddle PIO; replaces software polling for paddle motion.

Parameters:
- Y_WIDTH, 10: position width; matches PIO out_port width.
- Y_MIN, 0: lowest legal position.
- Y_MAX, 400: highest legal position (480 lines minus paddle height 80).
- Y_INIT, 200: position after reset.
- STEP, 4: pixels moved per tick.
- TICK_DIV, 833333: clk cycles per tick (60 Hz at 50 MHz); must be >= 2.
- TARGET_ADDR, 0: word address driven on avm_address.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- btn_up, input, 1: move-up request, active-high, asynchronous to clk.
- btn_down, input, 1: move-down request, active-high, asynchronous to clk.
- avm_address, output, 2: slave word address.
- avm_chipselect, output, 1: transaction valid.
- avm_write_n, output, 1: active-low write strobe.
- avm_writedata, output, 32: write data.
- avm_readdata, input, 32: read data (used only with the optional feature).
- avm_waitrequest, input, 1: slave stall.
- paddle_y, output, Y_WIDTH: current internal position.
- busy, output, 1: transaction in progress or pending.
- verify_err, output, 1: sticky readback mismatch.

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset). All state is updated on the clk rising edge only.
- Reset values:
  - paddle_y = Y_INIT; avm_chipselect = 0; avm_write_n = 1; avm_address = TARGET_ADDR; avm_writedata = 0; busy = 1; verify_err = 0.
  - pending = 1, so an initial write of Y_INIT is issued immediately after reset.
  - Tick counter = 0.
- Buttons: 2-flop synchronizer each; the synchronized level is used (no edge detect, holding a button moves continuously).
- Tick: counter counts 0..TICK_DIV-1; tick pulses for one cycle when the counter wraps to 0.
- Position update on tick:
  - up only: y = max(y-STEP, Y_MIN).
  - down only: y = min(y+STEP, Y_MAX).
  - Both or neither: no change.
  - Arithmetic is done in Y_WIDTH+1 bits so there is no wrap-around below 0 or above Y_MAX.
  - If the new y differs from the old y, set pending. At the limit, a clamped y equal to the old value causes no write.
- FSM states: IDLE, WRITE (plus VERIFY, optional).
  - IDLE: chipselect = 0, write_n = 1. If pending, then next cycle:
    - latch avm_writedata = zero-extended paddle_y;
    - clear pending;
    - go to WRITE.
  - WRITE: chipselect = 1, write_n = 0, address = TARGET_ADDR; writedata held stable.
    - Transfer completes on the rising edge where avm_waitrequest = 0.
    - On completion go to IDLE (or VERIFY).
    - Minimum 1 cycle in WRITE.
- Tick during WRITE: position updates and pending is set; the in-flight writedata is unchanged. After completion, IDLE immediately starts a new write with the latest y. Multiple ticks while stalled coalesce into one write of the final value.
- Same-cycle tick and write completion: both take effect; pending is set from the tick.
- busy = pending OR (state != IDLE).
- Reset mid-transaction: the bus is released on the next edge (chipselect = 0) and the FSM restarts from the reset values above.
- Unused writedata bits [31:Y_WIDTH] are always 0.

Optional Feature:
- Macro: PADDLE_READBACK_VERIFY_EN.
- With the macro:
  - After WRITE completes, enter VERIFY: chipselect = 1, write_n = 1, same address.
  - On the edge with waitrequest = 0, compare avm_readdata[Y_WIDTH-1:0] against the latched writedata.
  - On mismatch, set verify_err (sticky until reset) and set pending, so the current y is rewritten.
  - Go to IDLE.
- Without the macro: no VERIFY state; avm_readdata is ignored; verify_err is constant 0.

Test Plan:
1. Reset with waitrequest = 0 -> one write: chipselect = 1, write_n = 0, address = 0, writedata = 200 lasting 1 cycle; then busy = 0 and paddle_y = 200.
2. TICK_DIV = 4, btn_down held for 3 ticks -> paddle_y 204, 208, 212, with one write per tick carrying each value.
3. paddle_y = 2, btn_up held for 2 ticks -> y = 0 then stays 0; only one write (value 0); no wrap to 1022.
4. btn_up and btn_down held together for 5 ticks -> paddle_y unchanged, no chipselect assertion.
5. waitrequest held high for 10 cycles while 2 down-ticks occur (y 200 -> 208) -> writedata stays 200 throughout the stall; exactly one follow-up write of 208.
6. Macro defined, slave returns readdata = 0 after a write of 204 -> verify_err = 1 (stays 1), followed by a rewrite of 204; reset clears verify_err.
